// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, control struct and framebuffer address helper
// for the 640x480@60 scanout of the 160x120 framebuffer.
package vga_timing_pkg;
  localparam int H_VISIBLE   = 640;
  localparam int H_FRONT     = 16;
  localparam int H_SYNC      = 96;
  localparam int H_BACK      = 48;
  localparam int V_VISIBLE   = 480;
  localparam int V_FRONT     = 10;
  localparam int V_SYNC      = 2;
  localparam int V_BACK      = 33;

  localparam int H_TOTAL     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START    = H_VISIBLE + H_FRONT;
  localparam int HS_END      = HS_START + H_SYNC;
  localparam int VS_START    = V_VISIBLE + V_FRONT;
  localparam int VS_END      = VS_START + V_SYNC;

  localparam int SCALE_SHIFT = 2;
  localparam int FB_W        = 160;
  localparam int ADDR_W      = 15;
  localparam int CNT_W       = 10;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } vga_ctrl_t;

  // row*FB_W + col with FB_W = 160 = 128 + 32, so two shifts and adds.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [CNT_W-1:0] h,
                                                 input logic [CNT_W-1:0] v);
    logic [ADDR_W-1:0] row, col;
    row = ADDR_W'(v >> SCALE_SHIFT);
    col = ADDR_W'(h >> SCALE_SHIFT);
    return (row << 7) + (row << 5) + col;
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick phase, h/v raster counters, raw sync/active decode and the
// once-per-frame tick.
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             tick,
  output logic             pix_clk,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             active,
  output logic             hs_raw,
  output logic             vs_raw,
  output logic             frame_start
);
  localparam int HT  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HSS = H_VISIBLE + H_FRONT;
  localparam int HSE = HSS + H_SYNC;
  localparam int VSS = V_VISIBLE + V_FRONT;
  localparam int VSE = VSS + V_SYNC;

  logic phase;
  logic started;

  assign tick    = phase;
  assign pix_clk = phase;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase   <= 1'b0;
      started <= 1'b0;
      h       <= '0;
      v       <= '0;
    end else begin
      phase <= ~phase;
      if (tick) begin
        started <= 1'b1;
        if (h == CNT_W'(HT - 1)) begin
          h <= '0;
          v <= (v == CNT_W'(VT - 1)) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  assign active = (h < CNT_W'(H_VISIBLE)) && (v < CNT_W'(V_VISIBLE));
  assign hs_raw = !((h >= CNT_W'(HSS)) && (h < CNT_W'(HSE)));
  assign vs_raw = !((v >= CNT_W'(VSS)) && (v < CNT_W'(VSE)));

  // The origin tick right after reset is not a frame boundary, so it is skipped.
  assign frame_start = tick && started && (h == '0) && (v == '0);
endmodule

// File: rtl/vga_scanout.sv
// Framebuffer read side: address pipeline, 4x4 upscale and 3-bit colour
// expansion onto the 10-bit DAC channels, two ticks behind the raster counters.
module vga_scanout import vga_timing_pkg::*; #(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [2:0]        rd_data,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N,
  output logic [9:0]        VGA_R,
  output logic [9:0]        VGA_G,
  output logic [9:0]        VGA_B,
  output logic              frame_start,
  output logic              vblank
);
  logic             tick;
  logic [CNT_W-1:0] h, v;
  logic             active, hs_raw, vs_raw;
  vga_ctrl_t        ctrl1;
  logic [2:0][9:0]  rgb_q;

  vga_timing_gen #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .clk         (clk),
    .resetn      (resetn),
    .tick        (tick),
    .pix_clk     (VGA_CLK),
    .h           (h),
    .v           (v),
    .active      (active),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .frame_start (frame_start)
  );

  // Stage 1: issue the read and carry the matching control bits alongside.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_addr <= '0;
      ctrl1   <= '{hs: 1'b1, vs: 1'b1, act: 1'b0};
      vblank  <= 1'b0;
    end else if (tick) begin
      rd_addr <= active ? fb_addr(h, v) : '0;
      ctrl1   <= '{hs: hs_raw, vs: vs_raw, act: active};
      vblank  <= (v >= CNT_W'(V_VISIBLE));
    end
  end

  // Stage 2: rd_data has had a full clk to settle since the address moved.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      rgb_q       <= '0;
    end else if (tick) begin
      VGA_HS      <= ctrl1.hs;
      VGA_VS      <= ctrl1.vs;
      VGA_BLANK_N <= ctrl1.act;
      for (int c = 0; c < 3; c++)
        rgb_q[c] <= ctrl1.act ? {10{rd_data[c]}} : 10'd0;
    end
  end

  assign VGA_R      = rgb_q[2];
  assign VGA_G      = rgb_q[1];
  assign VGA_B      = rgb_q[0];
  assign VGA_SYNC_N = 1'b0;
endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken raster so whole frames fit a
// short run; expectations come from a per-pixel arithmetic model of the raster.
module tb_vga_scanout;
  localparam int HV = 160, HF = 8, HSW = 16, HB = 16;
  localparam int VV = 12,  VF = 2, VSW = 2,  VB = 3;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FR = HT * VT;
  localparam int FRAME_CLKS = 2 * FR;

  logic        clk = 1'b0;
  logic        resetn;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0]  VGA_R, VGA_G, VGA_B;
  logic        frame_start, vblank;

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) dut (
    .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .frame_start(frame_start), .vblank(vblank)
  );

  always #10 clk = ~clk;

  typedef struct { logic [14:0] addr; logic vb; } a_exp_t;
  typedef struct { logic hs; logic vs; logic bn; logic [9:0] r, g, b; } p_exp_t;

  a_exp_t     aq[$];
  p_exp_t     pq[$];
  logic [2:0] mem [0:19199];
  int         errors = 0, checks = 0;
  int         tk = 0;
  bit         mon_en = 1'b0;
  int         cyc = 0, last_fs = -1, fs_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", nm, act, exp, tk);
    end
  endtask

  function automatic bit is_active(int k);
    int h = k % HT, v = (k / HT) % VT;
    return (h < HV) && (v < VV);
  endfunction

  function automatic a_exp_t addr_model(int k);
    a_exp_t e;
    int h = k % HT, v = (k / HT) % VT;
    e.addr = is_active(k) ? 15'((v / 4) * 160 + h / 4) : 15'd0;
    e.vb   = (v >= VV);
    return e;
  endfunction

  function automatic p_exp_t pix_model(int k, logic [2:0] d);
    p_exp_t e;
    int h = k % HT, v = (k / HT) % VT;
    bit act = is_active(k);
    e.hs = !((h >= HV + HF) && (h < HV + HF + HSW));
    e.vs = !((v >= VV + VF) && (v < VV + VF + VSW));
    e.bn = act;
    e.r  = (act && d[2]) ? 10'h3FF : 10'd0;
    e.g  = (act && d[1]) ? 10'h3FF : 10'd0;
    e.b  = (act && d[0]) ? 10'h3FF : 10'd0;
    return e;
  endfunction

  task automatic do_reset(int nclk);
    mon_en = 1'b0;
    resetn = 1'b0;
    aq.delete();
    pq.delete();
    cyc = 0;
    last_fs = -1;
    fs_seen = 0;
    repeat (nclk) @(posedge clk);
    #1;
    chk("rst_hs", VGA_HS, 1);
    chk("rst_vs", VGA_VS, 1);
    chk("rst_blank_n", VGA_BLANK_N, 0);
    chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_vga_clk", VGA_CLK, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_vblank", vblank, 0);
    resetn = 1'b1;
    tk = 0;
    mon_en = 1'b1;
  endtask

  // Per pixel tick: queue the address due now and the colour due one tick later,
  // and keep rd_data as garbage except in the clk before the stage-2 capture.
  task automatic run(int n);
    logic [2:0] d;
    a_exp_t a;
    repeat (n) begin
      @(posedge clk); #1;
      if (tk == 0) begin
        pq.push_back('{hs: 1'b1, vs: 1'b1, bn: 1'b0, r: 10'd0, g: 10'd0, b: 10'd0});
        rd_data = 3'($urandom);
      end else begin
        a = addr_model(tk - 1);
        d = is_active(tk - 1) ? mem[a.addr] : 3'($urandom);
        rd_data = d;
        pq.push_back(pix_model(tk - 1, d));
      end
      aq.push_back(addr_model(tk));
      @(posedge clk); #1;
      rd_data = 3'($urandom);
      tk++;
    end
  endtask

  // Monitor: the DUT's outputs move on the edge where VGA_CLK falls.
  initial begin
    logic prev;
    a_exp_t a;
    p_exp_t p;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !VGA_CLK) begin
        if (aq.size() == 0 || pq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: output tick with no expectation queued (tick %0d)", tk);
        end else begin
          a = aq.pop_front();
          p = pq.pop_front();
          chk("rd_addr", rd_addr, a.addr);
          chk("vblank", vblank, a.vb);
          chk("hs", VGA_HS, p.hs);
          chk("vs", VGA_VS, p.vs);
          chk("blank_n", VGA_BLANK_N, p.bn);
          chk("r", VGA_R, p.r);
          chk("g", VGA_G, p.g);
          chk("b", VGA_B, p.b);
          chk("sync_n", VGA_SYNC_N, 0);
        end
      end
      prev = VGA_CLK;
    end
  end

  always @(posedge clk) if (resetn) cyc++;

  // The first pulse sits on the tick one frame after the first tick (cycle 1).
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && frame_start) begin
        fs_seen++;
        if (last_fs < 0) chk("fs_first", cyc, FRAME_CLKS + 1);
        else             chk("fs_period", cyc - last_fs, FRAME_CLKS);
        last_fs = cyc;
      end
    end
  end

  initial begin
    for (int i = 0; i < 19200; i++) mem[i] = 3'($urandom);
    mem[321] = 3'b001;
    mem[322] = 3'b101;
    rd_data  = 3'd0;
    resetn   = 1'b0;
    do_reset(5);
    run(2 * FR + 6 * HT + 50);
    chk("fs_count_run1", fs_seen, 2);
    do_reset(1);
    run(FR + 20);
    chk("fs_count_run2", fs_seen, 1);
    @(negedge clk); #1;
    chk("addr_q_drained", aq.size(), 0);
    chk("pix_q_drained", pq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Read side of the 160x120, 3-bit framebuffer that the game's pixel renderer writes.
- Generates 640x480@60 VGA timing from the 50 MHz clk using a 25 MHz pixel-tick enable.
- Upscales each stored pixel 4x4 by issuing framebuffer read addresses and expanding each 3-bit colour to the DAC channels.
- Also emits a once-per-frame pulse that game logic can use as its frame tick.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync width (ticks)
- H_BACK, 48, horizontal back porch (ticks)
- V_VISIBLE, 480, active lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SCALE_SHIFT, 2, log2 of the upscale factor
- FB_W, 160, framebuffer width in stored pixels
- ADDR_W, 15, framebuffer address width

Ports:
- clk  in  1  50 MHz system clock
- resetn  in  1  reset, synchronous, active-low
- rd_addr  out  ADDR_W  framebuffer read address, registered
- rd_data  in  3  framebuffer data; valid exactly 1 clk after rd_addr changes; bits are {R,G,B}
- VGA_CLK  out  1  25 MHz pixel clock to DAC
- VGA_HS  out  1  hsync, active-low
- VGA_VS  out  1  vsync, active-low
- VGA_BLANK_N  out  1  high during active video
- VGA_SYNC_N  out  1  tied 0 (no sync-on-green)
- VGA_R, VGA_G, VGA_B  out  10 each  channel intensity
- frame_start  out  1  one-clk pulse at start of each frame
- vblank  out  1  high while v counter >= V_VISIBLE

Behaviour:
- Reset values: phase=0, h=0, v=0, rd_addr=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0, VGA_CLK=0, frame_start=0, vblank=0. Reset asserted mid-line or mid-frame restarts the frame at h=0, v=0.
- Pixel tick: phase toggles every clk; a tick occurs on clk cycles where phase==1 (cycles 1, 3, 5, ... after reset release). VGA_CLK = registered phase.
- Counters: all state below advances only on a tick.
  - h counts 0..799 (H_TOTAL = sum of H params), then wraps to 0.
  - When h wraps, v increments 0..524, then wraps to 0.
- Active video: active = (h < 640) && (v < 480).
- Horizontal sync: hs_raw low for 656 <= h < 752.
- Vertical sync: vs_raw low for 490 <= v < 492.
- Stage 1 (on tick): register rd_addr and the control signals.
  - rd_addr = (v>>2)*160 + (h>>2), computed as (row<<7)+(row<<5)+col without a multiplier. Range 0..19199.
  - When not active, rd_addr = 0.
  - Also register hs1, vs1, act1.
- Stage 2 (next tick; rd_data has been stable for 1 clk): register outputs.
  - VGA_HS = hs1, VGA_VS = vs1, VGA_BLANK_N = act1.
  - Each channel = 10 copies of its colour bit when act1 is high, otherwise 0.
- Latency: outputs lag the counters by exactly 2 ticks (4 clks). Sync and colour remain mutually aligned.
- frame_start: high for one clk on the tick where h==0 && v==0 (counter values before the advance), after the first post-reset tick.
- vblank: registered at the same time as stage 1.
- Boundaries:
  - Last visible pixel is h=639, v=479, addr 19199.
  - h=640 gives blank output and addr 0.
  - Line wrap and frame wrap occur on the same tick with no extra idle cycle.
  - rd_data changing during blank has no effect on the outputs.

Decomposition:
- vga_timing_pkg holds the H/V timing constants, H_TOTAL=800, V_TOTAL=525, sync start/end derived constants, and FB_W.
- One sub-module, vga_timing_gen, contains the phase, h/v counters, hs_raw/vs_raw/active and frame_start.
- vga_scanout contains the address pipeline and colour expansion.

Test Plan:
- Reset: hold resetn=0 for 5 clks -> VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0, rd_addr=0. Release -> first tick at clk 1.
- Hsync timing: run 2 lines -> VGA_HS period 1600 clks, low for 192 clks. First falling edge 4 clks after the tick where h=656.
- Vsync/frame: run 2 frames -> frame_start pulses exactly 840000 clks apart. VGA_VS low for 3200 clks per frame. vblank high for 45 lines.
- Addressing: model RAM returning rd_data = addr[2:0] -> for h=4..7, v=8..11, rd_addr=321. Output colour 3'b001 -> VGA_B=10'h3FF, VGA_R=VGA_G=0.
- Colour expansion and blanking: rd_data=3'b101 -> VGA_R=VGA_B=10'h3FF, VGA_G=0 while active. All RGB=0 at h=640..799 regardless of rd_data.
- Mid-frame reset: assert resetn=0 for 1 clk at v=200 -> the next frame_start occurs 840000 clks after release. Outputs match the reset values during reset.
